// File: rtl/port_seg_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the 7-segment scanner.
//   digit_idx_t : index of one of the four display digits
//   seg7_t      : segment vector {g,f,e,d,c,b,a}
//   HEX_SEG     : active-high hex glyphs, indexed by nibble value
//   SEG_BLANK   : active-high "all segments off"
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg7_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to active-high 7-segment glyph decoder.
// Ports:
//   nibble : in  4  hex digit value
//   seg    : out 7  active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/port_seg_scanner.sv
// -----------------------------------------------------------------------------
// port_seg_scanner
// Snapshots CPU output ports A/B once per display frame and scans them as
// four hex digits on a multiplexed 7-segment display (digits 3..2 = port_A,
// digits 1..0 = port_B, decimal point on digit 2 as separator).
// Optional build macro: SEG_BLANK_LEADING_ZERO_EN blanks digit 3 / digit 1
// when the high nibble of the respective snapshot is zero.
// Parameters:
//   DIV          : clock cycles per digit slot (>= 2)
//   COMMON_ANODE : 1 = seg/dp/an active-low, 0 = active-high
// Ports:
//   clk        : in  1  system clock
//   reset      : in  1  asynchronous active-low reset
//   port_A     : in  8  CPU output port A
//   port_B     : in  8  CPU output port B
//   freeze     : in  1  keep current snapshot at frame wrap
//   seg        : out 7  segments {g,f,e,d,c,b,a}
//   dp         : out 1  decimal point
//   an         : out 4  one-hot digit enable
//   digit_idx  : out 2  currently enabled digit
//   frame_done : out 1  one-cycle pulse at each frame wrap
// -----------------------------------------------------------------------------
module port_seg_scanner
    import seg_pkg::*;
#(
    parameter int DIV          = 4,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_A,
    input  logic [7:0] port_B,
    input  logic       freeze,
    output seg7_t      seg,
    output logic       dp,
    output logic [3:0] an,
    output digit_idx_t digit_idx,
    output logic       frame_done
);

    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    // XOR masks turning active-high internal values into pin polarity.
    localparam seg7_t      SEG_INV = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_INV  = COMMON_ANODE ? 4'hF  : 4'h0;
    localparam logic       DP_INV  = COMMON_ANODE;

    logic [CW-1:0] div_cnt;
    logic [7:0]    snap_a;
    logic [7:0]    snap_b;

    logic          tick;
    logic          wrap;
    digit_idx_t    next_idx;
    logic [7:0]    snap_a_next;
    logic [7:0]    snap_b_next;
    logic [3:0]    nibble;
    seg7_t         dec_seg;
    seg7_t         seg_active;
    logic          blank;

    assign tick     = (div_cnt == DIV_LAST);
    assign next_idx = digit_idx + 2'd1;
    assign wrap     = (digit_idx == 2'd3);

    // The digit shown on the wrap edge must come from the snapshot being
    // loaded on that same edge, so decode from the "next" snapshot values.
    assign snap_a_next = (wrap && !freeze) ? port_A : snap_a;
    assign snap_b_next = (wrap && !freeze) ? port_B : snap_b;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        nibble = snap_b_next[3:0];
        case (next_idx)
            2'd0:    nibble = snap_b_next[3:0];
            2'd1:    nibble = snap_b_next[7:4];
            2'd2:    nibble = snap_a_next[3:0];
            default: nibble = snap_a_next[7:4];
        endcase
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_BLANK_LEADING_ZERO_EN
    assign blank = ((next_idx == 2'd3) && (snap_a_next[7:4] == 4'h0)) ||
                   ((next_idx == 2'd1) && (snap_b_next[7:4] == 4'h0));
`else
    assign blank = 1'b0;
`endif

    assign seg_active = blank ? SEG_BLANK : dec_seg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            digit_idx  <= 2'd3;
            snap_a     <= 8'h00;
            snap_b     <= 8'h00;
            frame_done <= 1'b0;
            seg        <= SEG_BLANK ^ SEG_INV;
            an         <= AN_INV;
            dp         <= DP_INV;
        end else begin
            frame_done <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + CW'(1);
            if (tick) begin
                digit_idx  <= next_idx;
                snap_a     <= snap_a_next;
                snap_b     <= snap_b_next;
                frame_done <= wrap;
                seg        <= seg_active ^ SEG_INV;
                an         <= (4'b0001 << next_idx) ^ AN_INV;
                dp         <= (next_idx == 2'd2) ^ DP_INV;
            end
        end
    end

endmodule

// File: tb/tb_port_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_port_seg_scanner
// Scoreboard bench for port_seg_scanner (DIV=4, COMMON_ANODE=1). The driver
// pushes the expected display state for every tick into a queue; the monitor
// pops an entry whenever the digit enable changes and otherwise checks that
// the outputs hold steady.
// -----------------------------------------------------------------------------
module tb_port_seg_scanner;

    localparam int DIV = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] port_A = 8'h00;
    logic [7:0] port_B = 8'h00;
    logic       freeze = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_done;

    always #10 clk = ~clk;

    port_seg_scanner #(
        .DIV          (DIV),
        .COMMON_ANODE (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .port_A     (port_A),
        .port_B     (port_B),
        .freeze     (freeze),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [1:0] idx;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         edge_cnt = 0;
    logic [7:0] ref_a = 8'h00;
    logic [7:0] ref_b = 8'h00;

    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. edge_cnt numbers rising edges since reset release;
    // every DIV-th edge is a tick, tick n shows digit n%4, digit 0 starts a frame.
    task automatic drive_cycle(input logic [7:0] a, input logic [7:0] b, input logic frz);
        int         n;
        int         d;
        logic [3:0] nib;
        exp_t       x;
        @(negedge clk);
        port_A = a;
        port_B = b;
        freeze = frz;
        edge_cnt++;
        if (edge_cnt % DIV == 0) begin
            n = edge_cnt / DIV - 1;
            d = n % 4;
            if (d == 0 && !frz) begin
                ref_a = a;
                ref_b = b;
            end
            case (d)
                0:       nib = ref_b[3:0];
                1:       nib = ref_b[7:4];
                2:       nib = ref_a[3:0];
                default: nib = ref_a[7:4];
            endcase
            x.seg = ~hex_pattern(nib);
`ifdef SEG_BLANK_LEADING_ZERO_EN
            if ((d == 1 || d == 3) && nib == 4'h0) x.seg = 7'h7F;
`endif
            x.an  = ~(4'b0001 << d);
            x.dp  = (d != 2);
            x.fd  = (d == 0);
            x.idx = 2'(d);
            q.push_back(x);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_an"},  an,         4'hF);
        check({tag, "_seg"}, seg,        7'h7F);
        check({tag, "_dp"},  dp,         1'b1);
        check({tag, "_fd"},  frame_done, 1'b0);
        check({tag, "_idx"}, digit_idx,  2'd3);
    endtask

    // Monitor: a change of the digit enable marks a tick.
    initial begin
        logic [3:0] p_an;
        logic [6:0] p_seg;
        logic       p_dp;
        logic [1:0] p_idx;
        int         wait_cnt;
        exp_t       x;
        p_an = 4'hF; p_seg = 7'h7F; p_dp = 1'b1; p_idx = 2'd3; wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                wait_cnt = 0;
            end else if (an !== p_an) begin
                check("queue_depth_at_tick", q.size(), 1);
                if (q.size() > 0) begin
                    x = q.pop_front();
                    check("tick_an",  an,         x.an);
                    check("tick_seg", seg,        x.seg);
                    check("tick_dp",  dp,         x.dp);
                    check("tick_fd",  frame_done, x.fd);
                    check("tick_idx", digit_idx,  x.idx);
                end
                wait_cnt = 0;
            end else begin
                check("hold_seg", seg, p_seg);
                check("hold_dp", dp, p_dp);
                check("hold_idx", digit_idx, p_idx);
                check("frame_done_idle", frame_done, 1'b0);
                if (q.size() != 0) begin
                    wait_cnt++;
                    if (wait_cnt > DIV) begin
                        check("tick_timeout", wait_cnt, DIV);
                        q.delete();
                        wait_cnt = 0;
                    end
                end
            end
            p_an = an; p_seg = seg; p_dp = dp; p_idx = digit_idx;
        end
    end

    // Stimulus
    initial begin
        logic [7:0] cur_a;
        logic [7:0] cur_b;
        logic       frz;

        #12;
        check_reset_values("reset");
        #3;
        reset = 1'b1;

        // Frame 0: A=3C B=05; A changes to FF while digit 1 is shown.
        for (int i = 0; i < 8; i++)  drive_cycle(8'h3C, 8'h05, 1'b0);
        for (int i = 0; i < 24; i++) drive_cycle(8'hFF, 8'h05, 1'b0);
        // Freeze across the wrap while B changes, then release.
        for (int i = 0; i < 8; i++)  drive_cycle(8'hFF, 8'h9A, 1'b1);
        for (int i = 0; i < 24; i++) drive_cycle(8'hFF, 8'h9A, 1'b0);

        // Random traffic, including zero high nibbles and random freeze.
        cur_a = 8'h00;
        cur_b = 8'h00;
        for (int i = 0; i < 16 * 10 + 6; i++) begin
            if ($urandom_range(0, 5) == 0)
                cur_a = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            if ($urandom_range(0, 5) == 0)
                cur_b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            frz = ($urandom_range(0, 3) == 0);
            drive_cycle(cur_a, cur_b, frz);
        end

        // Reset in the middle of a frame takes effect without a clock edge.
        @(posedge clk);
        #5;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        check("queue_empty_at_reset", q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #5;
        reset    = 1'b1;
        edge_cnt = 0;
        ref_a    = 8'h00;
        ref_b    = 8'h00;

        for (int i = 0; i < 32; i++) begin
            frz = ($urandom_range(0, 1) == 0);
            drive_cycle(8'($urandom), 8'($urandom), frz);
        end

        @(posedge clk);
        #2;
        check("queue_empty_end", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
